// File: rtl/hook_controller.sv
// Hook/rope engine for one Gold Miner player: swings the rope angle, launches on fire,
// extends, retracts empty or loaded, and tracks the rope tail pixel.
module hook_controller #(
    parameter logic [9:0]  PIVOT_X     = 10'd200,
    parameter logic [9:0]  PIVOT_Y     = 10'd60,
    parameter int unsigned SWING_TICKS = 2000000,
    parameter int unsigned FAST_TICKS  = 500000,
    parameter int unsigned LOAD_TICKS  = 2000000,
    parameter logic [7:0]  MAX_STEPS   = 8'd70
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       is_new_game_start,
    input  logic       fire,
    input  logic       is_catch,
    input  logic       is_explode,
    output logic [9:0] tailx,
    output logic [9:0] taily,
    output logic [3:0] R_mode,
    output logic [2:0] state_out,
    output logic       retract_done
);

    localparam int unsigned TICK_W = 32;

    typedef enum logic [2:0] {
        SWING        = 3'd0,
        EXTEND       = 3'd1,
        RETRACT      = 3'd2,
        RETRACT_LOAD = 3'd3
    } state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick, tick_nxt, period_m1;
    logic [7:0]          steps, steps_nxt;
    logic [3:0]          r_nxt;
    logic                dir_up, dir_up_nxt;
    logic                done_nxt;
    logic                step_ev, keep_tick, oob_c;
    logic signed [11:0]  dx_c, dy_c, tail_x_c, tail_y_c, next_x_c, next_y_c;

    // Per-angle step vector; out-of-range angles behave as angle 10.
    always_comb begin
        case (R_mode)
            4'd0:    begin dx_c = -12'sd6; dy_c = 12'sd0; end
            4'd1:    begin dx_c = -12'sd6; dy_c = 12'sd1; end
            4'd2:    begin dx_c = -12'sd5; dy_c = 12'sd2; end
            4'd3:    begin dx_c = -12'sd4; dy_c = 12'sd3; end
            4'd4:    begin dx_c = -12'sd2; dy_c = 12'sd4; end
            4'd5:    begin dx_c =  12'sd0; dy_c = 12'sd6; end
            4'd6:    begin dx_c =  12'sd2; dy_c = 12'sd4; end
            4'd7:    begin dx_c =  12'sd4; dy_c = 12'sd3; end
            4'd8:    begin dx_c =  12'sd5; dy_c = 12'sd2; end
            4'd9:    begin dx_c =  12'sd6; dy_c = 12'sd1; end
            default: begin dx_c =  12'sd6; dy_c = 12'sd0; end
        endcase
    end

    assign tail_x_c = $signed({2'b00, PIVOT_X}) + $signed({4'b0000, steps}) * dx_c;
    assign tail_y_c = $signed({2'b00, PIVOT_Y}) + $signed({4'b0000, steps}) * dy_c;
    assign next_x_c = tail_x_c + dx_c;
    assign next_y_c = tail_y_c + dy_c;
    assign oob_c    = (next_x_c < 12'sd0) || (next_x_c > 12'sd639) || (next_y_c > 12'sd479);

    always_comb begin
        case (state)
            SWING:        period_m1 = TICK_W'(SWING_TICKS - 1);
            RETRACT_LOAD: period_m1 = TICK_W'(LOAD_TICKS - 1);
            default:      period_m1 = TICK_W'(FAST_TICKS - 1);
        endcase
    end

    // >= so a tick carried over from the slow period still fires promptly.
    assign step_ev = (tick >= period_m1);

    always_comb begin
        state_nxt  = state;
        steps_nxt  = steps;
        r_nxt      = R_mode;
        dir_up_nxt = dir_up;
        done_nxt   = 1'b0;
        keep_tick  = 1'b0;
        case (state)
            SWING: begin
                if (R_mode > 4'd10) begin
                    r_nxt = 4'd10;
                end else if (fire) begin
                    state_nxt = EXTEND;
                end else if (step_ev) begin
                    if (dir_up) begin
                        if (R_mode == 4'd10) begin
                            r_nxt      = 4'd9;
                            dir_up_nxt = 1'b0;
                        end else begin
                            r_nxt = R_mode + 4'd1;
                        end
                    end else if (R_mode == 4'd0) begin
                        r_nxt      = 4'd1;
                        dir_up_nxt = 1'b1;
                    end else begin
                        r_nxt = R_mode - 4'd1;
                    end
                end
            end
            EXTEND: begin
                if (is_catch)
                    state_nxt = RETRACT_LOAD;
                else if ((steps >= MAX_STEPS) || oob_c)
                    state_nxt = RETRACT;
                else if (step_ev)
                    steps_nxt = steps + 8'd1;
            end
            RETRACT: begin
                if (steps == 8'd0) begin
                    state_nxt = SWING;
                    done_nxt  = 1'b1;
                end else if (step_ev) begin
                    steps_nxt = steps - 8'd1;
                end
            end
            RETRACT_LOAD: begin
                if (steps == 8'd0) begin
                    state_nxt = SWING;
                    done_nxt  = 1'b1;
                end else if (is_explode) begin
                    state_nxt = RETRACT;
                    keep_tick = 1'b1;
                end else if (step_ev) begin
                    steps_nxt = steps - 8'd1;
                end
            end
            default: state_nxt = SWING;
        endcase

        if ((state_nxt != state) && !keep_tick)
            tick_nxt = '0;
        else if (step_ev)
            tick_nxt = '0;
        else
            tick_nxt = tick + TICK_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (reset || is_new_game_start) begin
            state        <= SWING;
            R_mode       <= 4'd5;
            dir_up       <= 1'b1;
            steps        <= 8'd0;
            tick         <= '0;
            tailx        <= PIVOT_X;
            taily        <= PIVOT_Y;
            retract_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            R_mode       <= r_nxt;
            dir_up       <= dir_up_nxt;
            steps        <= steps_nxt;
            tick         <= tick_nxt;
            tailx        <= tail_x_c[9:0];
            taily        <= tail_y_c[9:0];
            retract_done <= done_nxt;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_hook_controller.sv
// Bench for hook_controller: two instances (pivot x 200 and 10) checked every cycle against
// a phase-based behavioural model, plus directed literal checks of each scenario.
module tb_hook_controller;

    logic       Clk = 1'b0;
    logic       reset, is_new_game_start, fire, is_catch, is_explode;
    logic [9:0] tx [2];
    logic [9:0] ty [2];
    logic [3:0] rm [2];
    logic [2:0] so [2];
    logic       rd [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    hook_controller #(.PIVOT_X(10'd200), .PIVOT_Y(10'd60), .SWING_TICKS(4), .FAST_TICKS(2),
                      .LOAD_TICKS(8), .MAX_STEPS(8'd5)) dut0 (
        .Clk(Clk), .reset(reset), .is_new_game_start(is_new_game_start), .fire(fire),
        .is_catch(is_catch), .is_explode(is_explode), .tailx(tx[0]), .taily(ty[0]),
        .R_mode(rm[0]), .state_out(so[0]), .retract_done(rd[0]));

    hook_controller #(.PIVOT_X(10'd10), .PIVOT_Y(10'd60), .SWING_TICKS(4), .FAST_TICKS(2),
                      .LOAD_TICKS(8), .MAX_STEPS(8'd5)) dut1 (
        .Clk(Clk), .reset(reset), .is_new_game_start(is_new_game_start), .fire(fire),
        .is_catch(is_catch), .is_explode(is_explode), .tailx(tx[1]), .taily(ty[1]),
        .R_mode(rm[1]), .state_out(so[1]), .retract_done(rd[1]));

    // ---------------- behavioural model ----------------
    // Swing angle is a position on a 20-step ping-pong ring: angle = p<=10 ? p : 20-p.
    int pvx [2] = '{200, 10};
    int m_mode [2], m_p [2], m_steps [2], m_tick [2], m_tx [2], m_ty [2], m_done [2];

    function automatic int ang(input int p);
        return (p <= 10) ? p : 20 - p;
    endfunction

    function automatic int dxf(input int r);
        case (r)
            0, 1:    return -6;
            2:       return -5;
            3:       return -4;
            4:       return -2;
            5:       return 0;
            6:       return 2;
            7:       return 4;
            8:       return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int dyf(input int r);
        case (r)
            0, 10:   return 0;
            1, 9:    return 1;
            2, 8:    return 2;
            3, 7:    return 3;
            4, 6:    return 4;
            default: return 6;
        endcase
    endfunction

    task automatic model_step(input int i);
        int  r, per, nm, nx, ny;
        bit  ev, keep;
        if (reset || is_new_game_start) begin
            m_mode[i] = 0; m_p[i] = 5; m_steps[i] = 0; m_tick[i] = 0;
            m_tx[i] = pvx[i]; m_ty[i] = 60; m_done[i] = 0;
            return;
        end
        r = ang(m_p[i]);
        m_tx[i]   = pvx[i] + m_steps[i] * dxf(r);
        m_ty[i]   = 60 + m_steps[i] * dyf(r);
        m_done[i] = 0;
        per  = (m_mode[i] == 0) ? 4 : ((m_mode[i] == 3) ? 8 : 2);
        ev   = (m_tick[i] >= per - 1);
        nm   = m_mode[i];
        keep = 1'b0;
        nx   = pvx[i] + (m_steps[i] + 1) * dxf(r);
        ny   = 60 + (m_steps[i] + 1) * dyf(r);
        case (m_mode[i])
            0: if (fire) nm = 1; else if (ev) m_p[i] = (m_p[i] + 1) % 20;
            1: if (is_catch) nm = 3;
               else if (m_steps[i] == 5 || nx < 0 || nx > 639 || ny > 479) nm = 2;
               else if (ev) m_steps[i]++;
            2: if (m_steps[i] == 0) begin nm = 0; m_done[i] = 1; end
               else if (ev) m_steps[i]--;
            default: if (m_steps[i] == 0) begin nm = 0; m_done[i] = 1; end
               else if (is_explode) begin nm = 2; keep = 1'b1; end
               else if (ev) m_steps[i]--;
        endcase
        if (nm != m_mode[i] && !keep) m_tick[i] = 0;
        else if (ev)                  m_tick[i] = 0;
        else                          m_tick[i]++;
        m_mode[i] = nm;
    endtask

    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model state dut%0d", i), int'(so[i]), m_mode[i]);
                check($sformatf("model R_mode dut%0d", i), int'(rm[i]), ang(m_p[i]));
                check($sformatf("model tailx dut%0d", i), int'(tx[i]), m_tx[i]);
                check($sformatf("model taily dut%0d", i), int'(ty[i]), m_ty[i]);
                check($sformatf("model retract_done dut%0d", i), int'(rd[i]), m_done[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset(input bit ng);
        if (ng) is_new_game_start = 1'b1; else reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        is_new_game_start = 1'b0;
    endtask

    function automatic int sel(input int kind, input int i);
        case (kind)
            0:       return int'(so[i]);
            1:       return int'(tx[i]);
            2:       return int'(ty[i]);
            default: return int'(rd[i]);
        endcase
    endfunction

    task automatic wait_eq(input string nm, input int kind, input int i, input int val,
                           input int lim, output int n);
        n = 0;
        while (sel(kind, i) != val && n < lim) begin
            @(negedge Clk);
            n++;
        end
        if (sel(kind, i) != val) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d, want %0d", nm, sel(kind, i), val);
        end
    endtask

    task automatic shoot();
        fire = 1'b1;
        cyc(1);
        fire = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; is_new_game_start = 1'b0; fire = 1'b0; is_catch = 1'b0; is_explode = 1'b0;
        cyc(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset state", int'(so[0]), 0);
        check("reset R_mode", int'(rm[0]), 5);
        check("reset tailx", int'(tx[0]), 200);
        check("reset taily", int'(ty[0]), 60);
        check("reset done", int'(rd[0]), 0);

        // Swing; stray catch/explode must do nothing
        cyc(3);
        is_catch = 1'b1; is_explode = 1'b1;
        cyc(1);
        is_catch = 1'b0; is_explode = 1'b0;
        cyc(16);
        check("swing R_mode at top", int'(rm[0]), 10);
        cyc(40);
        check("swing R_mode at bottom", int'(rm[0]), 0);
        check("swing tailx", int'(tx[0]), 200);
        check("swing taily", int'(ty[0]), 60);

        // Edge: pivot x=10 at angle 0 stops after one step
        shoot();
        wait_eq("edge retract", 0, 1, 2, 20, n);
        check("edge tailx", int'(tx[1]), 4);
        wait_eq("edge done", 3, 1, 1, 20, n);

        // Empty shot straight down
        do_reset(1'b1);
        shoot();
        wait_eq("empty extend end", 0, 0, 2, 30, n);
        check("empty max taily", int'(ty[0]), 90);
        wait_eq("empty done", 3, 0, 1, 30, n);
        check("empty home taily", int'(ty[0]), 60);
        check("empty home state", int'(so[0]), 0);
        cyc(1);
        check("empty done pulse width", int'(rd[0]), 0);

        // Catch at angle 10 after 3 steps, slow retract
        do_reset(1'b0);
        cyc(20);
        check("catch R_mode", int'(rm[0]), 10);
        shoot();
        wait_eq("catch tailx 218", 1, 0, 218, 20, n);
        is_catch = 1'b1;
        cyc(1);
        is_catch = 1'b0;
        check("catch state", int'(so[0]), 3);
        cyc(8);
        check("load tailx hold", int'(tx[0]), 218);
        cyc(1);
        check("load tailx step", int'(tx[0]), 212);
        wait_eq("load done", 3, 0, 1, 40, n);
        check("load home tailx", int'(tx[0]), 200);

        // Explode at steps=3 in loaded retract
        do_reset(1'b0);
        shoot();
        wait_eq("explode taily 78", 2, 0, 78, 20, n);
        is_catch = 1'b1;
        cyc(1);
        is_catch = 1'b0;
        check("explode pre state", int'(so[0]), 3);
        is_explode = 1'b1;
        cyc(1);
        is_explode = 1'b0;
        check("explode state", int'(so[0]), 2);
        wait_eq("explode done", 3, 0, 1, 20, n);
        check("explode cycles to done", n, 6);

        // Reset mid-extend
        do_reset(1'b0);
        shoot();
        wait_eq("midreset taily 78", 2, 0, 78, 20, n);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midreset state", int'(so[0]), 0);
        check("midreset R_mode", int'(rm[0]), 5);
        check("midreset tailx", int'(tx[0]), 200);
        check("midreset taily", int'(ty[0]), 60);
        check("midreset tailx dut1", int'(tx[1]), 10);
        check("midreset done", int'(rd[0]), 0);

        // fire held during retract is ignored
        shoot();
        wait_eq("fire-ign retract", 0, 0, 2, 30, n);
        fire = 1'b1;
        cyc(4);
        check("fire ignored in retract", int'(so[0]), 2);
        fire = 1'b0;
        wait_eq("fire-ign done", 3, 0, 1, 30, n);
        cyc(5);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
